link_buffer: RTL

- Flit FIFO on a single NoC link, placed directly upstream of a switch input port.
- Takes flits from an IP or a neighbouring switch and presents them to the switch `data_i` with the same write/read handshake.
- Supports two forwarding modes:
  - cut-through: forward each flit as soon as it is stored;
  - store-and-forward: present a packet only once its last flit is buffered.
- Provides per-link elasticity and decouples IP packet generation from switch arbitration.

---
 rtl/link_buffer.sv | 108 ++++++++++
 1 files changed

// File: rtl/link_buffer.sv
// link_buffer: flit FIFO for one NoC link, sitting just upstream of a switch input.
// The head flit is released cut-through (any flit stored) or store-and-forward (whole packet stored).
module link_buffer #(
    parameter int DATA_SIZE   = 8,
    parameter int ADDR_SIZE   = 2,
    parameter int MEM_LOG2    = 2,
    parameter int PACKET_MODE = 0,
    localparam int BUS_SIZE   = ADDR_SIZE + DATA_SIZE + 1
) (
    input  logic                clk,
    input  logic                a_rst,
    input  logic [BUS_SIZE-1:0] data_i,
    input  logic                in_w,
    output logic                out_r,
    output logic [BUS_SIZE-1:0] data_o,
    output logic                out_w,
    input  logic                in_r,
    output logic [MEM_LOG2:0]   count,
    output logic [MEM_LOG2:0]   pkts
);

    localparam int DEPTH = 2 ** MEM_LOG2;
    localparam logic [MEM_LOG2:0] FULL = (MEM_LOG2 + 1)'(DEPTH);
    localparam logic [MEM_LOG2:0] ZERO = '0;
    localparam logic [MEM_LOG2:0] ONE  = (MEM_LOG2 + 1)'(1);
    localparam logic [MEM_LOG2-1:0] PTR_ONE = (MEM_LOG2)'(1);

    logic [BUS_SIZE-1:0] r_mem [DEPTH];
    logic [MEM_LOG2-1:0] r_wr_ptr;
    logic [MEM_LOG2-1:0] r_rd_ptr;
    logic [MEM_LOG2:0]   r_count;
    logic [MEM_LOG2:0]   r_pkts;
    logic                r_alive;

    logic                w_wr;
    logic                w_rd;
    logic                w_in_last;
    logic                w_out_last;
    logic                w_has_flit;
    logic                w_release;
    logic [BUS_SIZE-1:0] w_head;
    logic [MEM_LOG2:0]   w_count_nxt;
    logic [MEM_LOG2:0]   w_pkts_nxt;

    assign w_head     = r_mem[r_rd_ptr];
    assign w_has_flit = (r_count != ZERO);
    assign w_in_last  = data_i[BUS_SIZE-1];
    assign w_out_last = w_head[BUS_SIZE-1];

    // Store-and-forward holds the head back until some packet is complete.
    generate
        if (PACKET_MODE != 0) begin : g_saf
            assign w_release = (r_pkts != ZERO);
        end else begin : g_ct
            assign w_release = w_has_flit;
        end
    endgenerate

    // r_alive keeps the link closed until the first edge after reset.
    assign out_r  = r_alive & (r_count != FULL);
    assign out_w  = w_release;
    assign data_o = w_has_flit ? w_head : '0;
    assign count  = r_count;
    assign pkts   = r_pkts;

    assign w_wr = in_w & out_r;
    assign w_rd = out_w & in_r;

    always_comb begin
        w_count_nxt = r_count;
        unique case ({w_wr, w_rd})
            2'b10:   w_count_nxt = r_count + ONE;
            2'b01:   w_count_nxt = r_count - ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    always_comb begin
        w_pkts_nxt = r_pkts;
        unique case ({w_wr & w_in_last, w_rd & w_out_last})
            2'b10:   w_pkts_nxt = r_pkts + ONE;
            2'b01:   w_pkts_nxt = r_pkts - ONE;
            default: w_pkts_nxt = r_pkts;
        endcase
    end

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            r_alive  <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_pkts   <= '0;
        end else begin
            r_alive <= 1'b1;
            r_count <= w_count_nxt;
            r_pkts  <= w_pkts_nxt;
            if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    // Storage is deliberately left out of reset; count gates what is visible.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= data_i;
    end

endmodule
